// File: rtl/encoder_pkg.sv
// encoder_pkg
//   Shared constants and helpers for the quadrature encoder reader.
//   - CHANNELS / COUNT_W : default channel count and position counter width
//   - VEL_W              : signed velocity accumulator width
//   - FIELD_*            : rd_sel field codes for the read mux
//   - GRAY_S0..S3        : {a,b} encodings along the forward rotation
//   - decode_step()      : classifies a previous->current {a,b} transition
package encoder_pkg;

  localparam int CHANNELS = 4;
  localparam int CH_IDX_W = 2;
  localparam int COUNT_W  = 16;
  localparam int VEL_W    = 8;

  localparam logic [1:0] FIELD_CNT_LO = 2'd0;
  localparam logic [1:0] FIELD_CNT_HI = 2'd1;
  localparam logic [1:0] FIELD_VEL    = 2'd2;
  localparam logic [1:0] FIELD_STATUS = 2'd3;

  // Forward rotation order: 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b01;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } step_e;

  // Position of an {a,b} pair along the forward rotation.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] pos;
    case (ab)
      GRAY_S0: pos = 2'd0;
      GRAY_S1: pos = 2'd1;
      GRAY_S2: pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

  // Distance of 1 is forward, 3 (i.e. -1 mod 4) is reverse, 2 means both
  // phases flipped at once, which a real encoder cannot produce.
  function automatic step_e decode_step(input logic [1:0] prev_ab,
                                        input logic [1:0] cur_ab);
    logic [1:0] diff;
    step_e      step;
    diff = gray_pos(cur_ab) - gray_pos(prev_ab);
    case (diff)
      2'd0:    step = STEP_NONE;
      2'd1:    step = STEP_FWD;
      2'd3:    step = STEP_REV;
      default: step = STEP_ILLEGAL;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/encoder_channel.sv
// encoder_channel
//   One quadrature channel: 2-flop synchronizer, Gray-step decoder,
//   wrapping position counter, saturating per-window velocity accumulator
//   and sticky illegal-transition flag.
// Ports:
//   clk, reset (async, active low)
//   enc_a, enc_b   raw encoder phases (asynchronous to clk)
//   clear          zero the count and error flag (wins over a same-cycle step)
//   window_tick    velocity window boundary: accumulator -> velocity
//   count          live position count (two's complement, wraps)
//   velocity       live velocity of the last completed window
//   error          sticky illegal-transition flag
//   dir            last direction (1 = reverse)
//   sync_ab        synchronized {a,b}
module encoder_channel #(
  parameter int COUNT_W = encoder_pkg::COUNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enc_a,
  input  logic                          enc_b,
  input  logic                          clear,
  input  logic                          window_tick,
  output logic [COUNT_W-1:0]            count,
  output logic [encoder_pkg::VEL_W-1:0] velocity,
  output logic                          error,
  output logic                          dir,
  output logic [1:0]                    sync_ab
);
  import encoder_pkg::*;

  logic [1:0]                meta_reg;
  logic [1:0]                sync_reg;
  logic [1:0]                prev_reg;
  logic [1:0]                settle_reg;
  logic [COUNT_W-1:0]        count_reg;
  logic signed [VEL_W-1:0]   acc_reg;
  logic signed [VEL_W-1:0]   acc_next;
  logic signed [VEL_W-1:0]   vel_reg;
  logic                      error_reg;
  logic                      dir_reg;
  logic                      settled;
  step_e                     step;
  logic signed [1:0]         inc;
  logic signed [VEL_W:0]     acc_sum;

  // After reset the synchronizer still holds zeros for two cycles while the
  // pins may already sit at a non-zero state. Decoding stays off until the
  // pipeline has refilled and prev_reg has loaded a real sample, so a
  // release with a = b = 1 neither counts nor flags an error.
  assign settled = (settle_reg == 2'd3);

  always_comb begin
    step = decode_step(prev_reg, sync_reg);
    inc  = 2'sd0;
    if (settled) begin
      case (step)
        STEP_FWD: inc = 2'sd1;
        STEP_REV: inc = -2'sd1;
        default:  inc = 2'sd0;
      endcase
    end

    // One extra bit of headroom detects overflow past +127 / -128.
    acc_sum = $signed({acc_reg[VEL_W-1], acc_reg})
            + $signed({{(VEL_W-1){inc[1]}}, inc});
    if (acc_sum[VEL_W] != acc_sum[VEL_W-1]) begin
      acc_next = acc_sum[VEL_W] ? {1'b1, {(VEL_W-1){1'b0}}}
                                : {1'b0, {(VEL_W-1){1'b1}}};
    end else begin
      acc_next = acc_sum[VEL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg   <= '0;
      sync_reg   <= '0;
      prev_reg   <= '0;
      settle_reg <= '0;
      count_reg  <= '0;
      acc_reg    <= '0;
      vel_reg    <= '0;
      error_reg  <= 1'b0;
      dir_reg    <= 1'b0;
    end else begin
      meta_reg <= {enc_a, enc_b};
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;

      if (!settled) begin
        settle_reg <= settle_reg + 2'd1;
      end

      if (clear) begin
        count_reg <= '0;
        error_reg <= 1'b0;
      end else begin
        count_reg <= count_reg + {{(COUNT_W-2){inc[1]}}, inc};
        if (settled && (step == STEP_ILLEGAL)) begin
          error_reg <= 1'b1;
        end
      end

      if (settled && (step == STEP_FWD)) begin
        dir_reg <= 1'b0;
      end else if (settled && (step == STEP_REV)) begin
        dir_reg <= 1'b1;
      end

      // The boundary cycle's own step is folded into the transferred value.
      if (window_tick) begin
        vel_reg <= acc_next;
        acc_reg <= '0;
      end else begin
        acc_reg <= acc_next;
      end
    end
  end

  assign count    = count_reg;
  assign velocity = vel_reg;
  assign error    = error_reg;
  assign dir      = dir_reg;
  assign sync_ab  = sync_reg;

endmodule

// File: rtl/quad_encoder_reader.sv
// quad_encoder_reader
//   Multi-channel quadrature encoder reader with position counters, windowed
//   velocity, sticky error flags and a latch-on-demand snapshot read port.
// Ports:
//   clk, reset (async, active low)
//   enc_a, enc_b  raw encoder phases per channel
//   latch         snapshot all live counts / velocities / status
//   clear_mask    per-channel clear of count and error flag
//   rd_sel        {channel[1:0], field[1:0]} selecting a snapshot byte
//   rd_data       selected snapshot byte (combinational)
//   enc_error     live sticky error flags
//   window_tick   one-cycle pulse at each velocity window boundary
module quad_encoder_reader #(
  parameter int CHANNELS = encoder_pkg::CHANNELS,
  parameter int COUNT_W  = encoder_pkg::COUNT_W,
  parameter int WINDOW   = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enc_a,
  input  logic [CHANNELS-1:0] enc_b,
  input  logic                latch,
  input  logic [CHANNELS-1:0] clear_mask,
  input  logic [3:0]          rd_sel,
  output logic [7:0]          rd_data,
  output logic [CHANNELS-1:0] enc_error,
  output logic                window_tick
);
  import encoder_pkg::*;

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [WIN_W-1:0]   win_cnt_reg;

  logic [COUNT_W-1:0] live_count [CHANNELS];
  logic [VEL_W-1:0]   live_vel   [CHANNELS];
  logic               live_dir   [CHANNELS];
  logic [1:0]         live_sync  [CHANNELS];

  logic [COUNT_W-1:0] snap_count_reg  [CHANNELS];
  logic [VEL_W-1:0]   snap_vel_reg    [CHANNELS];
  logic [3:0]         snap_status_reg [CHANNELS];

  logic [CH_IDX_W-1:0] rd_ch;
  logic [1:0]          rd_field;
  logic [15:0]         cnt16;

  // Window boundary is the last count value; the tick is decoded from the
  // counter so it is low while reset holds the counter at zero.
  assign window_tick = (win_cnt_reg == WIN_W'(WINDOW - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt_reg <= '0;
    end else if (window_tick) begin
      win_cnt_reg <= '0;
    end else begin
      win_cnt_reg <= win_cnt_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    encoder_channel #(
      .COUNT_W(COUNT_W)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .enc_a      (enc_a[gi]),
      .enc_b      (enc_b[gi]),
      .clear      (clear_mask[gi]),
      .window_tick(window_tick),
      .count      (live_count[gi]),
      .velocity   (live_vel[gi]),
      .error      (enc_error[gi]),
      .dir        (live_dir[gi]),
      .sync_ab    (live_sync[gi])
    );

    // Snapshots sample the pre-edge live values, so a same-cycle step,
    // clear or window transfer is not visible until the next latch.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        snap_count_reg[gi]  <= '0;
        snap_vel_reg[gi]    <= '0;
        snap_status_reg[gi] <= '0;
      end else if (latch) begin
        snap_count_reg[gi]  <= live_count[gi];
        snap_vel_reg[gi]    <= live_vel[gi];
        snap_status_reg[gi] <= {enc_error[gi], live_dir[gi], live_sync[gi]};
      end
    end
  end

  assign rd_ch    = rd_sel[3:2];
  assign rd_field = rd_sel[1:0];

  always_comb begin
    rd_data = '0;
    cnt16   = 16'($signed(snap_count_reg[rd_ch]));
    if (int'(rd_ch) < CHANNELS) begin
      case (rd_field)
        FIELD_CNT_LO: rd_data = cnt16[7:0];
        FIELD_CNT_HI: rd_data = cnt16[15:8];
        FIELD_VEL:    rd_data = snap_vel_reg[rd_ch];
        default:      rd_data = {4'b0000, snap_status_reg[rd_ch]};
      endcase
    end
  end

endmodule

// File: tb/tb_quad_encoder_reader.sv
// tb_quad_encoder_reader
//   Scoreboard bench: each scenario drives encoder phases, pushes the bytes
//   it expects on the read port into a queue, then drains the queue by
//   selecting each address and comparing rd_data.
module tb_quad_encoder_reader;

  localparam int CH  = 4;
  localparam int CW  = 16;
  // 200 single-cycle steps cannot fit in a 100-cycle window, so the bench
  // uses a wider window to keep the saturation scenario inside one window.
  localparam int WIN = 400;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] enc_a;
  logic [CH-1:0] enc_b;
  logic          latch;
  logic [CH-1:0] clear_mask;
  logic [3:0]    rd_sel;
  logic [7:0]    rd_data;
  logic [CH-1:0] enc_error;
  logic          window_tick;

  int tests_run    = 0;
  int tests_failed = 0;
  int pos [CH];

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] val;
  } rd_exp_t;

  rd_exp_t exp_q [$];
  string   tag_q [$];

  quad_encoder_reader #(
    .CHANNELS(CH),
    .COUNT_W (CW),
    .WINDOW  (WIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .latch      (latch),
    .clear_mask (clear_mask),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .enc_error  (enc_error),
    .window_tick(window_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] gray_of(input int p);
    logic [1:0] g;
    case (p)
      0:       g = 2'b00;
      1:       g = 2'b01;
      2:       g = 2'b11;
      default: g = 2'b10;
    endcase
    return g;
  endfunction

  task automatic apply_ch(input int ch);
    logic [1:0] g;
    g         = gray_of(pos[ch]);
    enc_a[ch] = g[1];
    enc_b[ch] = g[0];
  endtask

  task automatic step(input int ch, input bit fwd);
    @(negedge clk);
    pos[ch] = (pos[ch] + (fwd ? 1 : 3)) % 4;
    apply_ch(ch);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_latch();
    @(negedge clk);
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
  endtask

  task automatic pulse_clear(input logic [CH-1:0] mask);
    @(negedge clk);
    clear_mask = mask;
    @(negedge clk);
    clear_mask = '0;
  endtask

  task automatic expect_rd(input int ch, input int field, input logic [7:0] val,
                           input string tag);
    rd_exp_t e;
    e.sel = {2'(ch), 2'(field)};
    e.val = val;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    rd_exp_t e;
    string   t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      @(negedge clk);
      rd_sel = e.sel;
      #1;
      $display("[TB] %s: rd_sel=0x%0h rd_data=0x%02h", t, rd_sel, rd_data);
      check_eq(t, 32'(rd_data), 32'(e.val));
    end
  endtask

  // Returns at the falling edge where window_tick is first seen high.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 2 * WIN; n++) begin
      @(negedge clk);
      if (window_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("tick timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int period;

    reset      = 1'b0;
    enc_a      = '0;
    enc_b      = '0;
    latch      = 1'b0;
    clear_mask = '0;
    rd_sel     = 4'h0;
    for (int i = 0; i < CH; i++) pos[i] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset enc_error", 32'(enc_error), 32'd0);
    check_eq("reset window_tick", 32'(window_tick), 32'd0);
    check_eq("reset rd_data", 32'(rd_data), 32'd0);
    reset = 1'b1;
    settle();

    // Four forward steps on ch0
    for (int i = 0; i < 4; i++) step(0, 1'b1);
    settle();
    check_eq("fwd4 enc_error0", 32'(enc_error[0]), 32'd0);
    pulse_latch();
    expect_rd(0, 0, 8'h04, "fwd4 cnt_lo");
    expect_rd(0, 1, 8'h00, "fwd4 cnt_hi");
    expect_rd(0, 3, 8'h00, "fwd4 status");
    drain();

    // Clear then one reverse step: wrap below zero
    pulse_clear(4'b0001);
    step(0, 1'b0);
    settle();
    expect_rd(0, 0, 8'h04, "snap hold without latch");
    drain();
    pulse_latch();
    expect_rd(0, 0, 8'hFF, "rev1 cnt_lo");
    expect_rd(0, 1, 8'hFF, "rev1 cnt_hi");
    expect_rd(0, 3, 8'h06, "rev1 status");
    drain();

    // Illegal 00 -> 11 on ch2
    @(negedge clk);
    pos[2] = 2;
    apply_ch(2);
    settle();
    check_eq("illegal enc_error2", 32'(enc_error[2]), 32'd1);
    pulse_latch();
    expect_rd(2, 0, 8'h00, "illegal cnt_lo");
    expect_rd(2, 1, 8'h00, "illegal cnt_hi");
    expect_rd(2, 3, 8'h0B, "illegal status");
    drain();
    pulse_clear(4'b0100);
    check_eq("cleared enc_error", 32'(enc_error), 32'd0);

    // ch3 to 5, then step + latch + clear landing on the same edge
    for (int i = 0; i < 5; i++) step(3, 1'b1);
    settle();
    step(3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    latch      = 1'b1;
    clear_mask = 4'b1000;
    @(negedge clk);
    latch      = 1'b0;
    clear_mask = '0;
    expect_rd(3, 0, 8'h05, "latch+clear snap lo");
    expect_rd(3, 1, 8'h00, "latch+clear snap hi");
    drain();
    settle();
    pulse_latch();
    expect_rd(3, 0, 8'h00, "latch+clear live lo");
    expect_rd(3, 1, 8'h00, "latch+clear live hi");
    expect_rd(3, 3, 8'h03, "latch+clear status");
    drain();

    // Reset pulsed with all phases high
    @(negedge clk);
    reset = 1'b0;
    enc_a = '1;
    enc_b = '1;
    for (int i = 0; i < CH; i++) pos[i] = 2;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("post-reset enc_error", 32'(enc_error), 32'd0);
    pulse_latch();
    for (int i = 0; i < CH; i++) begin
      expect_rd(i, 0, 8'h00, $sformatf("post-reset ch%0d lo", i));
      expect_rd(i, 1, 8'h00, $sformatf("post-reset ch%0d hi", i));
      expect_rd(i, 3, 8'h03, $sformatf("post-reset ch%0d status", i));
    end
    drain();

    // Velocity: 200 forward steps inside one window saturate at +127
    wait_tick();
    for (int i = 0; i < 200; i++) step(1, 1'b1);
    wait_tick();
    pulse_latch();
    expect_rd(1, 2, 8'h7F, "vel saturate");
    drain();

    // 10 reverse steps; latch on the tick cycle sees the previous velocity
    for (int i = 0; i < 10; i++) step(1, 1'b0);
    wait_tick();
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
    expect_rd(1, 2, 8'h7F, "latch on tick vel");
    drain();
    pulse_latch();
    expect_rd(1, 2, 8'hF6, "vel -10");
    expect_rd(1, 0, 8'hBE, "ch1 cnt_lo");
    expect_rd(1, 1, 8'h00, "ch1 cnt_hi");
    expect_rd(1, 3, 8'h04, "ch1 status");
    drain();

    // Window period
    wait_tick();
    period = 0;
    for (int n = 0; n < 2 * WIN; n++) begin
      @(negedge clk);
      period++;
      if (window_tick) break;
    end
    check_eq("window period", 32'(period), 32'(WIN));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
